// File: rtl/mem_load_sequencer.sv
// Test-harness sequencer: streams a program into imem, runs the core until halt
// or cycle budget, then dumps a window of dmem to an output stream.
module mem_load_sequencer #(
    parameter int ADDR_W     = 10,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W:0]       load_len,
    input  logic [31:0]           run_cycles,
    input  logic [31:0]           halt_pc,
    input  logic [ADDR_W:0]       dump_len,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  tb_imem_we,
    output logic [ADDR_W-1:0]     tb_imem_addr,
    output logic [31:0]           tb_imem_wdata,
    output logic                  tb_dmem_re,
    output logic [ADDR_W-1:0]     tb_dmem_addr,
    input  logic [31:0]           tb_dmem_rdata,
    output logic                  tb_dmem_we,
    output logic [31:0]           tb_dmem_wdata,
    output logic [REG_ADDR_W-1:0] tb_reg_rd_addr,
    input  logic [31:0]           pc_out,
    output logic                  core_run,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP_RD,
        DUMP_WAIT,
        DUMP_OUT
    } state_e;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [ADDR_W:0] loadLen_q, loadLen_d;
    logic [ADDR_W:0] dumpLen_q, dumpLen_d;
    logic [ADDR_W:0] wordCnt_q, wordCnt_d;
    logic [ADDR_W:0] dumpCnt_q, dumpCnt_d;
    logic [31:0]     runLimit_q, runLimit_d;
    logic [31:0]     haltPc_q, haltPc_d;
    logic [31:0]     cycleCnt_q, cycleCnt_d;
    logic [31:0]     outData_q, outData_d;
    logic            timeout_q, timeout_d;
    logic            done_q, done_d;

    logic loadBeat, lastLoad, lastDump, runHalt, runExpire;

    assign loadBeat  = (state_q == LOAD) && in_valid;
    assign lastLoad  = (wordCnt_q == loadLen_q - CNT_ONE);
    assign lastDump  = (dumpCnt_q == dumpLen_q - CNT_ONE);
    assign runHalt   = (pc_out == haltPc_q);
    assign runExpire = (cycleCnt_q == runLimit_q - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            loadLen_q  <= '0;
            dumpLen_q  <= '0;
            wordCnt_q  <= '0;
            dumpCnt_q  <= '0;
            runLimit_q <= '0;
            haltPc_q   <= '0;
            cycleCnt_q <= '0;
            outData_q  <= '0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            loadLen_q  <= loadLen_d;
            dumpLen_q  <= dumpLen_d;
            wordCnt_q  <= wordCnt_d;
            dumpCnt_q  <= dumpCnt_d;
            runLimit_q <= runLimit_d;
            haltPc_q   <= haltPc_d;
            cycleCnt_q <= cycleCnt_d;
            outData_q  <= outData_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

    // Zero lengths/budgets are clamped to 1 so every countdown terminates.
    always_comb begin
        state_d    = state_q;
        loadLen_d  = loadLen_q;
        dumpLen_d  = dumpLen_q;
        wordCnt_d  = wordCnt_q;
        dumpCnt_d  = dumpCnt_q;
        runLimit_d = runLimit_q;
        haltPc_d   = haltPc_q;
        cycleCnt_d = cycleCnt_q;
        outData_d  = outData_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    loadLen_d  = (load_len == '0) ? CNT_ONE : load_len;
                    runLimit_d = (run_cycles == 32'd0) ? 32'd1 : run_cycles;
                    haltPc_d   = halt_pc;
                    dumpLen_d  = dump_len;
                    wordCnt_d  = '0;
                    dumpCnt_d  = '0;
                    cycleCnt_d = '0;
                    timeout_d  = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wordCnt_d = wordCnt_q + CNT_ONE;
                    if (lastLoad) begin
                        cycleCnt_d = '0;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                cycleCnt_d = cycleCnt_q + 32'd1;
                if (runHalt || runExpire) begin
                    timeout_d = !runHalt;
                    if (dumpLen_q != '0) begin
                        state_d = DUMP_RD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            DUMP_RD: begin
                state_d = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                outData_d = tb_dmem_rdata;
                state_d   = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (out_ready) begin
                    dumpCnt_d = dumpCnt_q + CNT_ONE;
                    if (lastDump) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DUMP_RD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready       = (state_q == LOAD);
        tb_imem_we     = loadBeat;
        tb_imem_addr   = wordCnt_q[ADDR_W-1:0];
        tb_imem_wdata  = loadBeat ? in_data : 32'd0;
        tb_dmem_re     = (state_q == DUMP_RD);
        tb_dmem_addr   = dumpCnt_q[ADDR_W-1:0];
        tb_dmem_we     = 1'b0;
        tb_dmem_wdata  = 32'd0;
        tb_reg_rd_addr = '0;
        core_run       = (state_q == RUN);
        out_valid      = (state_q == DUMP_OUT);
        out_data       = outData_q;
        busy           = (state_q != IDLE);
        done           = done_q;
        timeout        = timeout_q;
    end

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Bench for mem_load_sequencer: drives whole load/run/dump sequences and checks
// every strobe and data beat against a sequence-level model of the harness.
module tb_mem_load_sequencer;

    localparam int ADDR_W     = 10;
    localparam int REG_ADDR_W = 5;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [ADDR_W:0]       load_len;
    logic [31:0]           run_cycles;
    logic [31:0]           halt_pc;
    logic [ADDR_W:0]       dump_len;
    logic                  in_valid;
    logic [31:0]           in_data;
    logic                  in_ready;
    logic                  tb_imem_we;
    logic [ADDR_W-1:0]     tb_imem_addr;
    logic [31:0]           tb_imem_wdata;
    logic                  tb_dmem_re;
    logic [ADDR_W-1:0]     tb_dmem_addr;
    logic [31:0]           tb_dmem_rdata;
    logic                  tb_dmem_we;
    logic [31:0]           tb_dmem_wdata;
    logic [REG_ADDR_W-1:0] tb_reg_rd_addr;
    logic [31:0]           pc_out;
    logic                  core_run;
    logic                  out_valid;
    logic [31:0]           out_data;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic                  timeout;

    mem_load_sequencer #(.ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .load_len(load_len), .run_cycles(run_cycles), .halt_pc(halt_pc), .dump_len(dump_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .tb_imem_we(tb_imem_we), .tb_imem_addr(tb_imem_addr), .tb_imem_wdata(tb_imem_wdata),
        .tb_dmem_re(tb_dmem_re), .tb_dmem_addr(tb_dmem_addr), .tb_dmem_rdata(tb_dmem_rdata),
        .tb_dmem_we(tb_dmem_we), .tb_dmem_wdata(tb_dmem_wdata), .tb_reg_rd_addr(tb_reg_rd_addr),
        .pc_out(pc_out), .core_run(core_run),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vecCount = 0;
    int unsigned errCount = 0;

    logic [31:0] loadWords [1024];
    logic [31:0] dmem      [1024];
    logic [31:0] imemLog   [1024];
    logic [31:0] outLog    [1024];

    int unsigned writeTot = 0, readTot = 0, outTot = 0, runTot = 0, doneTot = 0, stallTot = 0;
    int unsigned writeBase = 0, readBase = 0, outBase = 0, runBase = 0, doneBase = 0, stallBase = 0;
    int          curLoadLen = 0;
    int          curDumpLen = 0;
    int          readyMode = 0;
    int unsigned monIdx;
    int          stallCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Core stand-in: pc steps by 4 per released cycle, starting at 0 on release.
    logic [29:0] runIdx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        runIdx <= '0;
        else if (core_run) runIdx <= runIdx + 30'd1;
        else               runIdx <= '0;
    end
    assign pc_out = {runIdx, 2'b00};

    // dmem returns noise except the cycle after a read, so capture timing matters.
    always @(posedge clk) begin
        tb_dmem_rdata <= tb_dmem_re ? dmem[tb_dmem_addr] : $urandom;
    end

    initial begin
        out_ready = 1'b0;
        stallCnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!busy) stallCnt = 0;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (out_valid && (outTot - outBase) == 1 && stallCnt < 4) begin
                        out_ready = 1'b0;
                        stallCnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare against the expected write/read/output streams.
    logic        prevStall = 1'b0;
    logic [31:0] prevData  = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("strobe_overlap",
                32'((tb_imem_we && tb_dmem_re) || (tb_imem_we && out_valid) || (tb_dmem_re && out_valid)), 0);
            checkOutput("imem_we_handshake", 32'(tb_imem_we), 32'(in_valid && in_ready));
            if (tb_imem_we) begin
                monIdx = writeTot - writeBase;
                checkOutput("imem_write_in_range", 32'(monIdx < curLoadLen), 1);
                checkOutput("imem_addr", 32'(tb_imem_addr), monIdx & 32'h3FF);
                checkOutput("imem_data", tb_imem_wdata, loadWords[monIdx[9:0]]);
                imemLog[monIdx[9:0]] = tb_imem_wdata;
                writeTot++;
            end
            if (tb_dmem_re) begin
                monIdx = readTot - readBase;
                checkOutput("dmem_read_in_range", 32'(monIdx < curDumpLen), 1);
                checkOutput("dmem_addr", 32'(tb_dmem_addr), monIdx & 32'h3FF);
                readTot++;
            end
            if (out_valid) begin
                if (prevStall) checkOutput("out_data_stable", out_data, prevData);
                if (!out_ready) stallTot++;
                if (out_ready) begin
                    monIdx = outTot - outBase;
                    checkOutput("out_data", out_data, dmem[monIdx[9:0]]);
                    outLog[monIdx[9:0]] = out_data;
                    outTot++;
                end
                prevStall = !out_ready;
                prevData  = out_data;
            end else begin
                prevStall = 1'b0;
            end
            if (core_run) runTot++;
            if (done) begin
                doneTot++;
                checkOutput("done_after_last_out", outTot - outBase, curDumpLen);
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},        32'(busy), 0);
        checkOutput({tag, "_core_run"},    32'(core_run), 0);
        checkOutput({tag, "_in_ready"},    32'(in_ready), 0);
        checkOutput({tag, "_out_valid"},   32'(out_valid), 0);
        checkOutput({tag, "_out_data"},    out_data, 0);
        checkOutput({tag, "_done"},        32'(done), 0);
        checkOutput({tag, "_timeout"},     32'(timeout), 0);
        checkOutput({tag, "_imem_we"},     32'(tb_imem_we), 0);
        checkOutput({tag, "_imem_addr"},   32'(tb_imem_addr), 0);
        checkOutput({tag, "_imem_wdata"},  tb_imem_wdata, 0);
        checkOutput({tag, "_dmem_re"},     32'(tb_dmem_re), 0);
        checkOutput({tag, "_dmem_addr"},   32'(tb_dmem_addr), 0);
        checkOutput({tag, "_dmem_we"},     32'(tb_dmem_we), 0);
        checkOutput({tag, "_dmem_wdata"},  tb_dmem_wdata, 0);
        checkOutput({tag, "_reg_rd_addr"}, 32'(tb_reg_rd_addr), 0);
    endtask

    // gapMode: 0 back-to-back, 1 every other cycle, 2 random gaps.
    task automatic driveLoad(input int n, input int gapMode, input bit midStart);
        for (int i = 0; i < n; i++) begin
            int guard;
            if (gapMode == 1 && i > 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
            end else if (gapMode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = loadWords[i];
            guard = 0;
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (!in_ready) begin
                checkOutput("load_ready_timeout", 32'(in_ready), 1);
                in_valid = 1'b0;
                return;
            end
            if (midStart && i == 2) begin
                start      = 1'b1;
                load_len   = 11'd1;
                dump_len   = 11'd0;
                run_cycles = 32'd1;
            end
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    // One full sequence; litRun < 0 means no hand-computed run length is supplied.
    task automatic applyStimulus(input int loadLen, input int rc, input logic [31:0] hp,
                                 input int dumpLen, input int gapMode, input int rdyMode,
                                 input bit directed, input int litRun);
        int limit;
        int expRun;
        int budget;
        bit expTo;
        for (int i = 0; i < loadLen; i++) loadWords[i] = directed ? 32'hA0 + 32'(i) : $urandom;
        for (int i = 0; i < dumpLen; i++) dmem[i] = directed ? 32'h100 + 32'(i) : $urandom;
        limit = (rc == 0) ? 1 : rc;
        if (hp[1:0] == 2'b00 && int'(hp >> 2) < limit) begin
            expRun = int'(hp >> 2) + 1;
            expTo  = 1'b0;
        end else begin
            expRun = limit;
            expTo  = 1'b1;
        end
        writeBase = writeTot; readBase = readTot; outBase = outTot;
        runBase = runTot; doneBase = doneTot; stallBase = stallTot;
        curLoadLen = loadLen;
        curDumpLen = dumpLen;
        readyMode  = rdyMode;
        load_len   = 11'(loadLen);
        run_cycles = 32'(rc);
        halt_pc    = hp;
        dump_len   = 11'(dumpLen);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        load_len   = 11'($urandom);
        run_cycles = $urandom;
        halt_pc    = $urandom;
        dump_len   = 11'($urandom);
        checkOutput("timeout_cleared_on_start", 32'(timeout), 0);
        checkOutput("busy_after_start", 32'(busy), 1);
        driveLoad(loadLen, gapMode, 1'b0);
        budget = expRun + 20 * dumpLen + 100;
        for (int c = 0; c < budget && doneTot == doneBase; c++) tick();
        checkOutput("done_seen", doneTot - doneBase, 1);
        repeat (3) tick();
        checkOutput("done_single_pulse", doneTot - doneBase, 1);
        checkOutput("imem_write_count", writeTot - writeBase, loadLen);
        checkOutput("run_length", runTot - runBase, expRun);
        checkOutput("timeout_sticky", 32'(timeout), 32'(expTo));
        checkOutput("dmem_read_count", readTot - readBase, dumpLen);
        checkOutput("out_word_count", outTot - outBase, dumpLen);
        checkOutput("busy_idle", 32'(busy), 0);
        if (litRun >= 0) checkOutput("run_length_literal", runTot - runBase, litRun);
        if (directed) begin
            for (int i = 0; i < loadLen && i < 8; i++) checkOutput("imem_literal", imemLog[i], 32'hA0 + 32'(i));
            for (int i = 0; i < dumpLen && i < 8; i++) checkOutput("out_literal", outLog[i], 32'h100 + 32'(i));
        end
        if (rdyMode == 2) checkOutput("stall_cycles", stallTot - stallBase, 4);
    endtask

    task automatic resetTest;
        bit found;
        for (int i = 0; i < 4; i++) loadWords[i] = $urandom;
        writeBase = writeTot; runBase = runTot; doneBase = doneTot;
        readBase = readTot; outBase = outTot;
        curLoadLen = 4;
        curDumpLen = 2;
        readyMode  = 0;
        load_len   = 11'd4;
        run_cycles = 32'd50;
        halt_pc    = 32'hFFFF_FFF0;
        dump_len   = 11'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        driveLoad(4, 2, 1'b1);
        checkOutput("mid_load_start_writes", writeTot - writeBase, 4);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (runTot - runBase == 3) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("run_cycle3_reached", 32'(found), 1);
        checkOutput("core_run_before_reset", 32'(core_run), 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid_run_reset");
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = $urandom;
        rst_n    = 1'b1;
        #1;
        checkOutput("release_imem_we", 32'(tb_imem_we), 0);
        checkOutput("release_dmem_re", 32'(tb_dmem_re), 0);
        tick();
        in_valid = 1'b0;
        checkOutput("release_busy", 32'(busy), 0);
        checkOutput("release_timeout", 32'(timeout), 0);
        checkOutput("no_done_after_abort", doneTot - doneBase, 0);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget, got %0d vectors, expected completion", vecCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        load_len   = '0;
        run_cycles = '0;
        halt_pc    = '0;
        dump_len   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("por");
        rst_n = 1'b1;
        tick();

        applyStimulus(4, 100, 32'h10, 0, 1, 0, 1'b1, 5);
        applyStimulus(3, 8, 32'hFFFF_0000, 0, 0, 0, 1'b0, 8);
        applyStimulus(2, 50, 32'h0, 3, 0, 2, 1'b1, 1);
        applyStimulus(1024, 0, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1);
        applyStimulus(5, 6, 32'h14, 1, 2, 1, 1'b0, 6);
        applyStimulus(1, 2, 32'hFFFF_FFFF, 1024, 0, 0, 1'b0, 2);
        resetTest();
        applyStimulus(3, 4, 32'h8, 2, 0, 0, 1'b1, 3);

        for (int s = 0; s < 12; s++) begin
            int          ll;
            int          rc;
            int          dl;
            logic [31:0] hp;
            ll = $urandom_range(1, 16);
            rc = $urandom_range(0, 20);
            dl = $urandom_range(0, 8);
            hp = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 24)) * 32'd4 : $urandom;
            applyStimulus(ll, rc, hp, dl, 2, 1, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/mem_load_sequencer.md
MEM_LOAD_SEQUENCER -- requirements
Module: mem_load_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10; imem/dmem word-address width (1024 words).
REQ-002 SHALL have parameter REG_ADDR_W, default 5; register-file backdoor address width.
REQ-003 SHALL have ports, clock and reset first:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load/run/dump sequence; honoured only in IDLE.
- load_len  input  ADDR_W+1  instruction words to load, 1..2^ADDR_W; sampled on start.
- run_cycles  input  32  maximum core run cycles; sampled on start.
- halt_pc  input  32  run stops early when pc_out equals this value; sampled on start.
- dump_len  input  ADDR_W+1  dmem words to dump, 0..2^ADDR_W; sampled on start.
- in_valid  input  1  instruction word available.
- in_data  input  32  instruction word.
- in_ready  output  1  accepts in_data when in_valid&&in_ready.
- tb_imem_we / tb_imem_addr / tb_imem_wdata  output  1/ADDR_W/32  imem backdoor write.
- tb_dmem_re / tb_dmem_addr  output  1/ADDR_W  dmem backdoor read.
- tb_dmem_rdata  input  32  dmem read data, valid the cycle after tb_dmem_re.
- tb_dmem_we / tb_dmem_wdata  output  1/32  tied 0.
- tb_reg_rd_addr  output  REG_ADDR_W  tied 0.
- pc_out  input  32  core program counter.
- core_run  output  1  1 releases the core from reset; 0 holds it.
- out_valid / out_data  output  1/32  dumped dmem word.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  1 in any state except IDLE.
- done  output  1  one-cycle pulse on entering IDLE from DUMP.
- timeout  output  1  sticky; set when run ended by run_cycles, cleared on next accepted start.

Function
REQ-004 SHALL implement states IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT.
REQ-005 IDLE: start=1 -> sample configuration inputs, clear word counter, go LOAD; start in any other state SHALL be ignored.
REQ-006 LOAD: in_ready=1; each accepted beat SHALL drive tb_imem_we=1, tb_imem_addr=counter, tb_imem_wdata=in_data in the same cycle (combinational from handshake), then increment counter.
REQ-007 LOAD: after the beat where counter==load_len-1 is accepted, go RUN next cycle; in_ready SHALL be 0 outside LOAD.
REQ-008 RUN: core_run=1 for every RUN cycle; cycle counter starts at 0 on entry and increments each RUN cycle.
REQ-009 RUN exit: pc_out==halt_pc (checked each RUN cycle, first cycle included) -> leave RUN; else cycle counter==run_cycles-1 -> set timeout, leave RUN; halt_pc match wins if both hold in the same cycle.
REQ-010 run_cycles==0 SHALL be treated as 1.
REQ-011 RUN exit: core_run deasserts the next cycle; go DUMP_RD if dump_len!=0, else IDLE with done=1.
REQ-012 DUMP_RD: tb_dmem_re=1, tb_dmem_addr=dump counter, one cycle, then DUMP_WAIT.
REQ-013 DUMP_WAIT: capture tb_dmem_rdata into out_data register, then DUMP_OUT.
REQ-014 DUMP_OUT: out_valid=1, out_data stable until out_ready=1; on handshake increment dump counter; last word (counter==dump_len-1) -> IDLE with done=1, else DUMP_RD; throughput one word per 3 cycles minimum.
REQ-015 Address counters SHALL be ADDR_W+1 bits so load_len/dump_len of 2^ADDR_W complete without wrap; only the low ADDR_W bits drive addresses.
REQ-016 tb_imem_we, tb_dmem_re, out_valid SHALL never be asserted simultaneously.

Reset
REQ-017 rst_n=0 SHALL immediately force IDLE, all counters 0, timeout 0, and all outputs 0 (including core_run, in_ready, out_valid, done, busy), regardless of state.
REQ-018 Reset mid-LOAD/RUN/DUMP SHALL abandon the sequence; no write or read SHALL issue in the cycle rst_n deasserts; next start begins a fresh sequence.

Verification
REQ-019 Load 4 words (0xA0..0xA3) with in_valid gapped every other cycle -> imem writes addr 0..3 with those data, exactly 4 tb_imem_we pulses, then RUN.
REQ-020 halt_pc=0x10, pc_out reaches 0x10 on RUN cycle 5, run_cycles=100 -> core_run high exactly 5 cycles, timeout=0.
REQ-021 run_cycles=8, halt_pc never matched -> core_run high exactly 8 cycles, timeout=1 until next start.
REQ-022 dump_len=3, dmem model returns addr+0x100, out_ready held low 4 cycles on word 1 -> out_data 0x100,0x101,0x102 in order, word 1 stable while stalled, done pulse after third handshake.
REQ-023 load_len=1024, dump_len=0 -> addresses 0..1023 written, no wrap, no dmem reads, done pulse on RUN exit.
REQ-024 rst_n asserted during RUN cycle 3, start pulsed during LOAD -> core_run drops asynchronously, all outputs 0; mid-LOAD start ignored (counter unchanged).
